// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered decode/control stage for the 6-bit-opcode ISA.
// The stage decodes the opcode into execute, memory and writeback controls.
// It holds them in an ID/EX register with a valid/ready handshake.
// It stalls a consumer behind a load for LOAD_BUBBLES cycles.
// A flush from EX kills the output register and the hazard history.
// Optional feature: define ILLEGAL_OP_TRAP_EN to turn accepted undefined
// opcodes into bubbles and raise a sticky illegal_op flag.
`timescale 1ns/1ps

module ctrl_decode_stage #(
    parameter int OPCODE_W     = 6,
    parameter int EXEC_W       = 5,
    parameter int REG_W        = 5,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    src1,
    input  logic [REG_W-1:0]    src2,
    input  logic [REG_W-1:0]    dest,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EXEC_W-1:0]   exec_cmd,
    output logic                is_imm,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic                wb_en,
    output logic                is_br,
    output logic                br_type,
    output logic                is_jmp,
    output logic                st_or_bne,
    output logic [REG_W-1:0]    out_dest,
    output logic                illegal_op
);

    // Decoded controls for the opcode currently presented
    logic [EXEC_W-1:0] dec_exec;
    logic              dec_is_imm;
    logic              dec_mem_r;
    logic              dec_mem_w;
    logic              dec_wb;
    logic              dec_is_br;
    logic              dec_br_type;
    logic              dec_is_jmp;
    logic              dec_st_or_bne;
    logic              dec_defined;
    logic              dec_rtype;
    logic              dec_src1_used;
    logic              dec_src2_used;

    // Output register state
    logic              out_valid_reg;
    logic [EXEC_W-1:0] exec_cmd_reg;
    logic              is_imm_reg;
    logic              mem_r_en_reg;
    logic              mem_w_en_reg;
    logic              wb_en_reg;
    logic              is_br_reg;
    logic              br_type_reg;
    logic              is_jmp_reg;
    logic              st_or_bne_reg;
    logic [REG_W-1:0]  out_dest_reg;

    // Handshake
    logic adv;
    logic hazard;
    logic accept;
    logic issue;
    logic load_push;

    // Opcode decode: exec command, control flags and which sources are read
    always_comb begin
        dec_exec      = '0;
        dec_is_imm    = 1'b0;
        dec_mem_r     = 1'b0;
        dec_mem_w     = 1'b0;
        dec_wb        = 1'b0;
        dec_is_br     = 1'b0;
        dec_br_type   = 1'b0;
        dec_is_jmp    = 1'b0;
        dec_st_or_bne = 1'b0;
        dec_defined   = 1'b0;
        dec_rtype     = 1'b0;
        case (opcode)
            OPCODE_W'(1):  begin dec_rtype = 1'b1; dec_exec = EXEC_W'(0); end
            OPCODE_W'(3):  begin dec_rtype = 1'b1; dec_exec = EXEC_W'(1); end
            OPCODE_W'(5):  begin dec_rtype = 1'b1; dec_exec = EXEC_W'(2); end
            OPCODE_W'(6):  begin dec_rtype = 1'b1; dec_exec = EXEC_W'(3); end
            OPCODE_W'(7):  begin dec_rtype = 1'b1; dec_exec = EXEC_W'(4); end
            OPCODE_W'(8):  begin dec_rtype = 1'b1; dec_exec = EXEC_W'(5); end
            OPCODE_W'(9):  begin dec_rtype = 1'b1; dec_exec = EXEC_W'(6); end
            OPCODE_W'(10): begin dec_rtype = 1'b1; dec_exec = EXEC_W'(7); end
            OPCODE_W'(11): begin dec_rtype = 1'b1; dec_exec = EXEC_W'(8); end
            OPCODE_W'(12): begin dec_rtype = 1'b1; dec_exec = EXEC_W'(9); end
            OPCODE_W'(32): begin
                dec_defined = 1'b1; dec_exec = EXEC_W'(0);
                dec_is_imm  = 1'b1; dec_wb   = 1'b1;
            end
            OPCODE_W'(33): begin
                dec_defined = 1'b1; dec_exec = EXEC_W'(1);
                dec_is_imm  = 1'b1; dec_wb   = 1'b1;
            end
            OPCODE_W'(36): begin
                dec_defined = 1'b1; dec_exec  = EXEC_W'(0);
                dec_is_imm  = 1'b1; dec_mem_r = 1'b1; dec_wb = 1'b1;
            end
            OPCODE_W'(37): begin
                dec_defined = 1'b1; dec_exec  = EXEC_W'(0);
                dec_is_imm  = 1'b1; dec_mem_w = 1'b1; dec_st_or_bne = 1'b1;
            end
            OPCODE_W'(40): begin
                dec_defined = 1'b1; dec_exec  = EXEC_W'(14);
                dec_is_imm  = 1'b1; dec_is_br = 1'b1; dec_br_type = 1'b1;
            end
            OPCODE_W'(41): begin
                dec_defined = 1'b1; dec_exec  = EXEC_W'(15);
                dec_is_imm  = 1'b1; dec_is_br = 1'b1; dec_st_or_bne = 1'b1;
            end
            OPCODE_W'(42): begin
                dec_defined = 1'b1; dec_exec   = EXEC_W'(16);
                dec_is_imm  = 1'b1; dec_is_jmp = 1'b1;
            end
            default: ;
        endcase
        if (dec_rtype) begin
            dec_defined = 1'b1;
            dec_wb      = 1'b1;
        end
        // Jump is the only defined opcode that ignores src1
        dec_src1_used = dec_defined && (opcode != OPCODE_W'(42));
        dec_src2_used = dec_rtype || (opcode == OPCODE_W'(37)) ||
                        (opcode == OPCODE_W'(40)) || (opcode == OPCODE_W'(41));
    end

    assign adv       = !out_valid_reg || out_ready;
    assign in_ready  = adv && !hazard && !flush;
    assign accept    = in_valid && in_ready;
    // Only loads writing a real register can stall a later consumer
    assign load_push = accept && dec_mem_r && (dest != '0);

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_op_reg;

    // Sticky trap flag raised by any accepted undefined opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op_reg <= 1'b0;
        end else if (accept && !dec_defined) begin
            illegal_op_reg <= 1'b1;
        end
    end

    assign illegal_op = illegal_op_reg;
    // An undefined opcode is swallowed and becomes a bubble
    assign issue      = accept && dec_defined;
`else
    assign illegal_op = 1'b0;
    assign issue      = accept;
`endif

    // ID/EX output register: flush kills, otherwise load or bubble on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            exec_cmd_reg  <= '0;
            is_imm_reg    <= 1'b0;
            mem_r_en_reg  <= 1'b0;
            mem_w_en_reg  <= 1'b0;
            wb_en_reg     <= 1'b0;
            is_br_reg     <= 1'b0;
            br_type_reg   <= 1'b0;
            is_jmp_reg    <= 1'b0;
            st_or_bne_reg <= 1'b0;
            out_dest_reg  <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= issue;
            if (issue) begin
                exec_cmd_reg  <= dec_exec;
                is_imm_reg    <= dec_is_imm;
                mem_r_en_reg  <= dec_mem_r;
                mem_w_en_reg  <= dec_mem_w;
                wb_en_reg     <= dec_wb;
                is_br_reg     <= dec_is_br;
                br_type_reg   <= dec_br_type;
                is_jmp_reg    <= dec_is_jmp;
                st_or_bne_reg <= dec_st_or_bne;
                out_dest_reg  <= dest;
            end
        end
    end

    // Load-use history: entry 0 is the newest load, shifting once per advance
    generate
        if (LOAD_BUBBLES > 0) begin : g_hist
            logic             hist_valid_reg [LOAD_BUBBLES];
            logic [REG_W-1:0] hist_idx_reg   [LOAD_BUBBLES];
            logic [LOAD_BUBBLES-1:0] entry_hit;

            for (genvar gi = 0; gi < LOAD_BUBBLES; gi++) begin : g_entry
                assign entry_hit[gi] = hist_valid_reg[gi] && (
                    (dec_src1_used && (src1 != '0) && (src1 == hist_idx_reg[gi])) ||
                    (dec_src2_used && (src2 != '0) && (src2 == hist_idx_reg[gi])));

                if (gi == 0) begin : g_head
                    // Newest slot captures the load being accepted, if any
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            hist_valid_reg[gi] <= 1'b0;
                            hist_idx_reg[gi]   <= '0;
                        end else if (flush) begin
                            hist_valid_reg[gi] <= 1'b0;
                        end else if (adv) begin
                            hist_valid_reg[gi] <= load_push;
                            hist_idx_reg[gi]   <= dest;
                        end
                    end
                end else begin : g_tail
                    // Older slots take the entry one position younger
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            hist_valid_reg[gi] <= 1'b0;
                            hist_idx_reg[gi]   <= '0;
                        end else if (flush) begin
                            hist_valid_reg[gi] <= 1'b0;
                        end else if (adv) begin
                            hist_valid_reg[gi] <= hist_valid_reg[gi-1];
                            hist_idx_reg[gi]   <= hist_idx_reg[gi-1];
                        end
                    end
                end
            end

            assign hazard = in_valid && (|entry_hit);
        end else begin : g_no_hist
            assign hazard = 1'b0;
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign exec_cmd  = exec_cmd_reg;
    assign is_imm    = is_imm_reg;
    assign mem_r_en  = mem_r_en_reg;
    assign mem_w_en  = mem_w_en_reg;
    assign wb_en     = wb_en_reg;
    assign is_br     = is_br_reg;
    assign br_type   = br_type_reg;
    assign is_jmp    = is_jmp_reg;
    assign st_or_bne = st_or_bne_reg;
    assign out_dest  = out_dest_reg;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: two instances share the stimulus,
// dut_a with LOAD_BUBBLES=1 and dut_b with LOAD_BUBBLES=2.
`timescale 1ns/1ps

module tb_ctrl_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] opcode;
    logic [4:0] src1, src2, dest;
    logic       flush;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_is_imm, a_mem_r_en, a_mem_w_en, a_wb_en;
    logic       a_is_br, a_br_type, a_is_jmp, a_st_or_bne, a_illegal_op;
    logic [4:0] a_exec_cmd, a_out_dest;
    logic       b_in_ready, b_out_valid, b_is_imm, b_mem_r_en, b_mem_w_en, b_wb_en;
    logic       b_is_br, b_br_type, b_is_jmp, b_st_or_bne, b_illegal_op;
    logic [4:0] b_exec_cmd, b_out_dest;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage #(.LOAD_BUBBLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .opcode(opcode), .src1(src1), .src2(src2), .dest(dest), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .exec_cmd(a_exec_cmd),
        .is_imm(a_is_imm), .mem_r_en(a_mem_r_en), .mem_w_en(a_mem_w_en),
        .wb_en(a_wb_en), .is_br(a_is_br), .br_type(a_br_type), .is_jmp(a_is_jmp),
        .st_or_bne(a_st_or_bne), .out_dest(a_out_dest), .illegal_op(a_illegal_op)
    );

    ctrl_decode_stage #(.LOAD_BUBBLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .opcode(opcode), .src1(src1), .src2(src2), .dest(dest), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .exec_cmd(b_exec_cmd),
        .is_imm(b_is_imm), .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en),
        .wb_en(b_wb_en), .is_br(b_is_br), .br_type(b_br_type), .is_jmp(b_is_jmp),
        .st_or_bne(b_st_or_bne), .out_dest(b_out_dest), .illegal_op(b_illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input int s1, input int s2, input int d);
        in_valid = 1'b1;
        opcode   = 6'(op);
        src1     = 5'(s1);
        src2     = 5'(s2);
        dest     = 5'(d);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        opcode   = '0;
        src1     = '0;
        src2     = '0;
        dest     = '0;
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; src1 = '0; src2 = '0;
        dest = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_exec_cmd", a_exec_cmd, 0);
        chk("rst_wb_en", a_wb_en, 0);
        chk("rst_out_dest", a_out_dest, 0);
        chk("rst_illegal", a_illegal_op, 0);
        rst_n = 1'b1;
        tick();

        // Opcode 8: R-type, exec 5, writes back
        drive(8, 1, 2, 3);
        #1 chk("op8_in_ready", a_in_ready, 1);
        tick();
        chk("op8_out_valid", a_out_valid, 1);
        chk("op8_exec", a_exec_cmd, 5);
        chk("op8_wb", a_wb_en, 1);
        chk("op8_dest", a_out_dest, 3);
        chk("op8_imm", a_is_imm, 0);
        chk("op8_memr", a_mem_r_en, 0);
        chk("op8_br", a_is_br, 0);

        // bne then jmp back-to-back
        drive(41, 1, 2, 0);
        tick();
        chk("bne_valid", a_out_valid, 1);
        chk("bne_exec", a_exec_cmd, 15);
        chk("bne_is_br", a_is_br, 1);
        chk("bne_br_type", a_br_type, 0);
        chk("bne_st_or_bne", a_st_or_bne, 1);
        chk("bne_imm", a_is_imm, 1);
        drive(42, 0, 0, 0);
        tick();
        chk("jmp_valid", a_out_valid, 1);
        chk("jmp_exec", a_exec_cmd, 16);
        chk("jmp_is_jmp", a_is_jmp, 1);
        chk("jmp_wb", a_wb_en, 0);
        chk("jmp_is_br", a_is_br, 0);
        idle(3);

        // Load-use with one bubble
        drive(36, 1, 0, 2);
        tick();
        chk("ld_valid", a_out_valid, 1);
        chk("ld_memr", a_mem_r_en, 1);
        chk("ld_wb", a_wb_en, 1);
        drive(1, 3, 2, 5);
        #1 chk("use_stall_ready", a_in_ready, 0);
        tick();
        chk("use_bubble_valid", a_out_valid, 0);
        chk("use_retry_ready", a_in_ready, 1);
        tick();
        chk("use_valid", a_out_valid, 1);
        chk("use_dest", a_out_dest, 5);
        idle(3);

        // Register 0 sources never stall
        drive(36, 1, 0, 2);
        tick();
        drive(1, 0, 0, 6);
        #1 chk("r0_ready", a_in_ready, 1);
        tick();
        chk("r0_valid", a_out_valid, 1);
        chk("r0_dest", a_out_dest, 6);
        idle(3);

        // Two bubbles: ld r4, independent add, then sub reading r4
        drive(36, 1, 0, 4);
        tick();
        chk("lb2_ld_valid", b_out_valid, 1);
        drive(1, 6, 7, 5);
        #1 chk("lb2_add_ready", b_in_ready, 1);
        tick();
        chk("lb2_add_valid", b_out_valid, 1);
        chk("lb2_add_dest", b_out_dest, 5);
        drive(3, 4, 1, 6);
        #1 chk("lb2_sub_stall", b_in_ready, 0);
        tick();
        chk("lb2_bubble", b_out_valid, 0);
        chk("lb2_sub_ready", b_in_ready, 1);
        tick();
        chk("lb2_sub_valid", b_out_valid, 1);
        chk("lb2_sub_exec", b_exec_cmd, 1);
        chk("lb2_sub_dest", b_out_dest, 6);
        idle(3);

        // Back-pressure on a held load, then flush
        drive(36, 1, 0, 9);
        tick();
        chk("bp_ld_valid", a_out_valid, 1);
        out_ready = 1'b0;
        drive(1, 1, 1, 7);
        #1 chk("bp_ready_c1", a_in_ready, 0);
        tick();
        chk("bp_valid_c1", a_out_valid, 1);
        chk("bp_dest_c1", a_out_dest, 9);
        chk("bp_memr_c1", a_mem_r_en, 1);
        chk("bp_ready_c2", a_in_ready, 0);
        flush = 1'b1;
        #1 chk("flush_ready", a_in_ready, 0);
        tick();
        chk("flush_valid", a_out_valid, 0);
        flush = 1'b0;
        drive(1, 9, 0, 7);
        #1 chk("flush_hist_clear", a_in_ready, 1);
        tick();
        chk("post_flush_valid", a_out_valid, 1);
        chk("post_flush_dest", a_out_dest, 7);
        out_ready = 1'b1;
        idle(2);

        // Undefined opcode 2
        drive(2, 0, 0, 3);
        tick();
`ifdef ILLEGAL_OP_TRAP_EN
        chk("illegal_flag", a_illegal_op, 1);
        chk("illegal_valid", a_out_valid, 0);
        idle(2);
        chk("illegal_sticky", a_illegal_op, 1);
`else
        chk("undef_valid", a_out_valid, 1);
        chk("undef_exec", a_exec_cmd, 0);
        chk("undef_wb", a_wb_en, 0);
        chk("undef_imm", a_is_imm, 0);
        chk("undef_memw", a_mem_w_en, 0);
        chk("undef_illegal", a_illegal_op, 0);
        idle(2);
`endif

        // Asynchronous reset between edges
        drive(8, 1, 2, 3);
        tick();
        chk("pre_rst_valid", a_out_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", a_out_valid, 0);
        chk("async_rst_dest", a_out_dest, 0);
        chk("async_rst_illegal", a_illegal_op, 0);
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        chk("after_rst_valid", a_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered decode/control stage for the 6-bit-opcode ISA.
- Decodes the incoming opcode into execute, memory and writeback controls and holds them in an ID/EX output register with a valid/ready handshake.
- Detects load-use hazards and inserts a parametrised number of bubbles.
- Accepts a flush from EX on a taken branch or jump. Sits between fetch/regfile-read and the EX stage.

Parameters:
- OPCODE_W, 6: opcode width.
- EXEC_W, 5: exec_cmd width; must hold the value 16.
- REG_W, 5: register index width.
- LOAD_BUBBLES, 1: bubbles inserted between a load and a dependent consumer; legal range 0..3.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream instruction valid.
- in_ready, output, 1: stage accepts the instruction this cycle.
- opcode, input, OPCODE_W: instruction opcode.
- src1, input, REG_W: first source register.
- src2, input, REG_W: second source register.
- dest, input, REG_W: destination register.
- flush, input, 1: kill the output register and hazard history.
- out_valid, output, 1: output register holds a valid instruction.
- out_ready, input, 1: EX accepts the output this cycle.
- exec_cmd, output, EXEC_W: ALU command (registered).
- is_imm, mem_r_en, mem_w_en, wb_en, is_br, br_type, is_jmp, st_or_bne: outputs, 1 bit each; registered controls.
- out_dest, output, REG_W: registered destination.
- illegal_op, output, 1: sticky illegal-opcode flag (optional feature).

Behaviour:
- Decode table, opcode -> exec_cmd:
  - 1->0, 3->1, 5->2, 6->3, 7->4, 8->5, 9->6, 10->7, 11->8, 12->9 (R-type).
  - 32 addi->0, 33 subi->1, 36 ld->0, 37 st->0, 40 bez->14, 41 bne->15, 42 jmp->16.
  - Any other opcode is undefined: all controls 0, exec_cmd 0.
- Control flags:
  - is_imm: opcodes 32, 33, 36, 37, 40, 41, 42.
  - mem_r_en: 36 only. mem_w_en: 37 only.
  - wb_en: R-type, 32, 33, 36 only. Undefined opcodes never write back.
  - is_br: 40, 41. br_type: 40. is_jmp: 42. st_or_bne: 37, 41.
- Source usage:
  - src1 is read by every defined opcode except 42.
  - src2 is read by R-type, 37, 40 and 41.
  - Register 0 never creates a hazard.
- Reset: out_valid = 0, all control outputs = 0, out_dest = 0, hazard history cleared, illegal_op = 0.
- Advance: adv = !out_valid | out_ready.
- Accept condition: in_ready = adv & !hazard & !flush. On accept, the output register loads the decoded controls and out_valid = 1 next cycle. Latency is 1 cycle from accept to out_valid.
- If adv and no accept, out_valid = 0 next cycle (bubble). If !adv, all output registers hold; outputs stay stable while out_valid & !out_ready.
- Hazard history: shift register of LOAD_BUBBLES entries, each holding a valid bit and a register index.
  - On every adv cycle it shifts by one. Entry 0 is loaded with dest if the accepted instruction is a load with dest != 0; otherwise entry 0 is invalid.
  - No shift when !adv.
  - hazard = in_valid & (any valid entry index equals a used, nonzero source).
  - With LOAD_BUBBLES = 0 there is no history and hazard is always 0.
- Result: with out_ready held at 1, exactly LOAD_BUBBLES out_valid = 0 cycles separate a load from its dependent.
- Flush: out_valid = 0 and all history entries invalid on the next edge; in_ready = 0 during the flush cycle. Flush overrides accept and back-pressure.
- Simultaneous accept and out_ready: the old entry leaves and the new one loads on the same edge, so throughput is 1 instruction per cycle.
- Reset mid-stall: returns to reset state immediately (asynchronous); no bubble remains pending.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined:
  - An accepted undefined opcode sets illegal_op = 1 (sticky until reset).
  - The instruction is converted into a bubble: out_valid = 0 next cycle.
- Undefined:
  - An undefined opcode passes through with out_valid = 1 and all controls 0.
  - illegal_op is tied to 0.

Test Plan:
- Reset, then opcode 8 (src 1, 2, dest 3) with in_valid = 1 and out_ready = 1 -> next cycle out_valid = 1, exec_cmd = 5, wb_en = 1, out_dest = 3, other flags 0.
- Opcode 41, then 42, back-to-back -> consecutive cycles show {exec_cmd = 15, is_br = 1, br_type = 0, st_or_bne = 1, is_imm = 1}, then {exec_cmd = 16, is_jmp = 1, wb_en = 0}.
- LOAD_BUBBLES = 1: ld dest 2, then opcode 1 with src2 = 2 -> out_valid pattern 1, 0, 1; in_ready = 0 for exactly one cycle. Repeat with src = 0 -> no bubble.
- LOAD_BUBBLES = 2: ld r4, add r5 (independent), then sub reading r4 -> pattern 1, 1, 0, 1.
- out_ready = 0 for 3 cycles with an opcode-36 instruction held -> outputs and out_dest stable, in_ready = 0. Assert flush in cycle 2 -> out_valid = 0 next cycle, history cleared.
- Opcode 2 accepted -> with ILLEGAL_OP_TRAP_EN: illegal_op = 1 and out_valid = 0. Without it: out_valid = 1, all controls 0, illegal_op = 0.
